// File: rtl/img_ingest_pkg.sv
// Shared types and default sizing for the frame ingest path.
// The top and the frame memory both pick up their defaults from here.
package img_ingest_pkg;
    localparam int PIX_W       = 8;
    localparam int PIX_PER_IMG = 256;
    localparam int IMG_IDX_W   = 9;

    typedef logic [PIX_W-1:0]     pixel_t;
    typedef logic [IMG_IDX_W-1:0] img_idx_t;

    typedef enum logic {IDLE, RUN}    sess_state_e;
    typedef enum logic {EMPTY, FULL}  bank_state_e;
endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port.
// The MSB of each address selects the bank and the low bits select the pixel.
module frame_bank_ram
    import img_ingest_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int AW = $clog2(PIX_PER_IMG) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // The read register is reset so the output is 0 while in reset; the array is not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_ingest_buffer.sv
// Ping-pong ingest stage: fills one frame bank from the pixel stream while the
// hash engine reads the other bank, then releases it with frame_ack.
module frame_ingest_buffer
    import img_ingest_pkg::*;
#(
    parameter int PIX_W       = img_ingest_pkg::PIX_W,
    parameter int PIX_PER_IMG = img_ingest_pkg::PIX_PER_IMG,
    parameter int IMG_IDX_W   = img_ingest_pkg::IMG_IDX_W,
    parameter int ADDR_W      = $clog2(PIX_PER_IMG)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [IMG_IDX_W-1:0] num_images_i,
    input  logic [PIX_W-1:0]     pixel_data_i,
    input  logic                 pixel_valid_i,
    output logic                 pixel_ready_o,
    output logic                 frame_valid_o,
    output logic [IMG_IDX_W-1:0] frame_id_o,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [PIX_W-1:0]     rd_data_o,
    input  logic                 frame_ack_i,
    output logic                 busy_o,
    output logic                 all_frames_done_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_PER_IMG - 1);

    sess_state_e          state_q;
    bank_state_e          bank_st_q [2];
    logic [IMG_IDX_W-1:0] bank_id_q [2];
    logic [IMG_IDX_W-1:0] num_q, rx_cnt_q, ack_cnt_q;
    logic                 wr_bank_q, rd_bank_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic                 done_q;
    logic                 accept, ack;

    assign pixel_ready_o = (state_q == RUN) && (bank_st_q[wr_bank_q] == EMPTY)
                           && (rx_cnt_q < num_q);
    assign frame_valid_o = (bank_st_q[rd_bank_q] == FULL);
    assign frame_id_o    = bank_id_q[rd_bank_q];
    assign busy_o        = (state_q == RUN);
    assign all_frames_done_o = done_q;

    assign accept = pixel_valid_i && pixel_ready_o;
    assign ack    = frame_ack_i && frame_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bank_st_q  <= '{EMPTY, EMPTY};
            bank_id_q  <= '{'0, '0};
            num_q      <= '0;
            rx_cnt_q   <= '0;
            ack_cnt_q  <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (num_images_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            num_q     <= num_images_i;
                            rx_cnt_q  <= '0;
                            ack_cnt_q <= '0;
                            wr_bank_q <= 1'b0;
                            rd_bank_q <= 1'b0;
                            wr_addr_q <= '0;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (wr_addr_q == LAST_ADDR) begin
                            bank_st_q[wr_bank_q] <= FULL;
                            bank_id_q[wr_bank_q] <= rx_cnt_q;
                            wr_bank_q <= ~wr_bank_q;
                            wr_addr_q <= '0;
                            rx_cnt_q  <= rx_cnt_q + 1'b1;
                        end else begin
                            wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                    // Fill and ack always target different banks, so both may land together.
                    if (ack) begin
                        bank_st_q[rd_bank_q] <= EMPTY;
                        rd_bank_q <= ~rd_bank_q;
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                        if (ack_cnt_q == num_q - 1'b1) begin
                            state_q   <= IDLE;
                            done_q    <= 1'b1;
                            rx_cnt_q  <= '0;
                            ack_cnt_q <= '0;
                            wr_bank_q <= 1'b0;
                            rd_bank_q <= 1'b0;
                            wr_addr_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    frame_bank_ram #(
        .DW (PIX_W),
        .AW (ADDR_W + 1)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, wr_addr_q}),
        .wdata_i (pixel_data_i),
        .raddr_i ({rd_bank_q, rd_addr_i}),
        .rdata_o (rd_data_o)
    );
endmodule

// File: tb/tb_frame_ingest_buffer.sv
// Randomized sessions against a counting model of the ingest buffer:
// images received vs. images acked decide ready/valid/id, pixel arrays give rd_data.
module tb_frame_ingest_buffer;
    localparam int PW  = 12;
    localparam int PPI = 20;
    localparam int IW  = 9;
    localparam int AW  = $clog2(PPI);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] num = '0;
    logic [PW-1:0] pdata = '0;
    logic          pvalid = 1'b0;
    logic          pready;
    logic          fvalid;
    logic [IW-1:0] fid;
    logic [AW-1:0] raddr = '0;
    logic [PW-1:0] rdata;
    logic          fack = 1'b0;
    logic          busy;
    logic          done;

    frame_ingest_buffer #(
        .PIX_W(PW), .PIX_PER_IMG(PPI), .IMG_IDX_W(IW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_images_i(num),
        .pixel_data_i(pdata), .pixel_valid_i(pvalid), .pixel_ready_o(pready),
        .frame_valid_o(fvalid), .frame_id_o(fid), .rd_addr_i(raddr),
        .rd_data_o(rdata), .frame_ack_i(fack), .busy_o(busy),
        .all_frames_done_o(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit            m_run, m_done, rd_pend;
    int            m_num, m_recv, m_acked, m_cnt, m_totpx;
    int            rd_img, rd_a;
    logic [PW-1:0] img [0:63][0:PPI-1];
    int            vpct, apct, amode, stall;

    function automatic bit m_ready();
        return m_run && (m_recv - m_acked < 2) && (m_recv < m_num);
    endfunction

    function automatic bit m_fv();
        return m_recv > m_acked;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_run = 0; m_done = 0; rd_pend = 0;
        m_recv = 0; m_acked = 0; m_cnt = 0; stall = 0;
    endtask

    task automatic step();
        bit acc, ack;
        @(negedge clk);
        chk("pixel_ready", 32'(pready), 32'(m_ready()));
        chk("frame_valid", 32'(fvalid), 32'(m_fv()));
        if (m_fv()) chk("frame_id", 32'(fid), 32'(m_acked));
        chk("busy", 32'(busy), 32'(m_run));
        chk("all_frames_done", 32'(done), 32'(m_done));
        if (rd_pend) chk("rd_data", 32'(rdata), 32'(img[rd_img][rd_a]));
        @(posedge clk);
        acc = pvalid && m_ready();
        ack = fack && m_fv();
        rd_pend = m_fv();
        rd_img  = m_acked;
        rd_a    = int'(raddr);
        m_done  = 0;
        if (m_run) begin
            if (acc) begin
                img[m_recv][m_cnt] = pdata;
                m_cnt++;
                m_totpx++;
                if (m_cnt == PPI) begin
                    m_cnt = 0;
                    m_recv++;
                end
            end
            if (ack) begin
                m_acked++;
                if (m_acked == m_num) begin
                    m_run = 0; m_done = 1;
                    m_recv = 0; m_acked = 0; m_cnt = 0;
                end
            end
        end else if (start) begin
            if (num == '0) m_done = 1;
            else begin
                m_run = 1; m_num = int'(num);
                m_recv = 0; m_acked = 0; m_cnt = 0;
            end
        end
        if (ack) stall = 0;
        else if (m_run && !m_ready()) stall++;
        #1;
    endtask

    task automatic drive();
        pvalid = ($urandom_range(99) < vpct);
        pdata  = PW'($urandom());
        raddr  = AW'($urandom_range(PPI - 1));
        case (amode)
            1: fack = m_fv() && ((m_recv == 1 && m_cnt == PPI - 1) || m_recv >= 2);
            2: fack = (stall >= 5);
            default: fack = ($urandom_range(99) < apct);
        endcase
        // Start pulses during a session must be ignored.
        if (m_run && $urandom_range(99) < 3) begin
            start = 1'b1;
            num   = IW'($urandom_range(1, 5));
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pvalid = 1'b0; fack = 1'b0; start = 1'b0;
        #1;
        chk("rst pixel_ready", 32'(pready), 0);
        chk("rst frame_valid", 32'(fvalid), 0);
        chk("rst frame_id", 32'(fid), 0);
        chk("rst rd_data", 32'(rdata), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_session(input int n, input int vp, input int ap, input int am,
                               input int abort_px);
        int cyc;
        vpct = vp; apct = ap; amode = am; stall = 0; m_totpx = 0;
        start = 1'b1; num = IW'(n); pvalid = 1'b0; fack = 1'b0;
        step();
        start = 1'b0;
        cyc = 0;
        while ((m_run || m_done) && cyc < 3000) begin
            drive();
            step();
            cyc++;
            if (abort_px > 0 && m_totpx >= abort_px) begin
                do_reset();
                return;
            end
        end
        chk("session timeout", 32'(cyc < 3000), 1);
        pvalid = 1'b0; fack = 1'b0; start = 1'b0;
        step();
        step();
    endtask

    initial begin
        model_clear();
        m_totpx = 0;
        do_reset();
        run_session(1, 100, 0, 2, 0);   // single image, ack after a short stall
        run_session(3, 100, 0, 2, 0);   // both banks fill, ready drops until ack
        run_session(3, 100, 0, 1, 0);   // ack of bank 0 lands with last pixel into bank 1
        run_session(0, 100, 50, 0, 0);  // empty session: immediate done pulse
        run_session(3, 100, 50, 0, 7);  // aborted by reset partway into image 0
        run_session(2, 80, 40, 0, 0);
        for (int s = 0; s < 6; s++)
            run_session($urandom_range(1, 6), 60, 30, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
